// File: rtl/not_array_tester_if.sv
// not_array_tester_if: start/response/stimulus/status bundle between the tester and its surroundings.
interface not_array_tester_if;
   logic       start;
   logic [7:0] resp;
   logic [7:0] stim;
   logic       busy;
   logic       done;
   logic       pass;
   logic [8:0] err_count;
   logic       first_err_valid;
   logic [7:0] first_err_pattern;
   modport master (input start, resp,
                   output stim, busy, done, pass, err_count, first_err_valid, first_err_pattern);
   modport slave (output start, resp,
                  input stim, busy, done, pass, err_count, first_err_valid, first_err_pattern);
endinterface

// File: rtl/not_array_tester.sv
// not_array_tester: sweeps all 256 stimuli through the NOT array, samples after SETTLE cycles
// and checks each response against the inverted stimulus.
module not_array_tester #(
   parameter int unsigned SETTLE = 2
) (
   input logic clk,
   input logic rst_n,
   not_array_tester_if.master io
);
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_e;
   state_e     state_q, state_d;
   logic [7:0] stim_q, stim_d, fep_q, fep_d;
   logic [8:0] err_q, err_d, err_inc;
   logic [3:0] cnt_q, cnt_d;
   logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d, fev_q, fev_d, mis;
   assign mis     = io.resp != ~stim_q;
   assign err_inc = err_q + 9'(mis);
   always_comb begin
      state_d = state_q;
      stim_d  = stim_q;
      fep_d   = fep_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      fev_d   = fev_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (io.start) begin
            state_d = ST_SETTLE;
            stim_d  = 8'h00;
            fep_d   = 8'h00;
            err_d   = 9'd0;
            cnt_d   = 4'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fev_d   = 1'b0;
         end
         ST_SETTLE: begin
            cnt_d   = cnt_q + 4'd1;
            state_d = (cnt_q == 4'(SETTLE - 1)) ? ST_CHECK : ST_SETTLE;
         end
         ST_CHECK: begin
            err_d = err_inc;
            if (mis && !fev_q) begin
               fev_d = 1'b1;
               fep_d = stim_q;
            end
            // The final pattern ends the run before the increment, so stim never wraps.
            if (stim_q == 8'hFF) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = err_inc == 9'd0;
            end else begin
               state_d = ST_SETTLE;
               stim_d  = stim_q + 8'd1;
               cnt_d   = 4'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         stim_q  <= 8'h00;
         fep_q   <= 8'h00;
         err_q   <= 9'd0;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fev_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         fep_q   <= fep_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fev_q   <= fev_d;
      end
   end
   assign io.stim              = stim_q;
   assign io.busy              = busy_q;
   assign io.done              = done_q;
   assign io.pass              = pass_q;
   assign io.err_count         = err_q;
   assign io.first_err_valid   = fev_q;
   assign io.first_err_pattern = fep_q;
endmodule

// File: tb/tb_not_array_tester.sv
// tb_not_array_tester: drives two testers (SETTLE=2 and SETTLE=1) against modelled gate arrays
// with injected faults and checks run length and reported results.
module tb_not_array_tester;
   logic clk = 1'b0;
   logic rst_n;
   logic start_a, start_b, sel;
   int   mode_a, mode_b;
   int   n_cmp = 0, n_bad = 0;
   logic [7:0] fmask [256];
   logic [7:0] a1, a2, b1, b2;
   not_array_tester_if ia ();
   not_array_tester_if ib ();
   not_array_tester #(.SETTLE(2)) dut_a (.clk(clk), .rst_n(rst_n), .io(ia));
   not_array_tester #(.SETTLE(1)) dut_b (.clk(clk), .rst_n(rst_n), .io(ib));
   always #5 clk = ~clk;
   // Array models: 0 good, 1 resp[3] stuck-at-0, 2 A5 reads 00, 3 wire-through,
   // 4 random fault mask, 5 one-cycle-late array, 6 two-cycle-late array.
   function automatic logic [7:0] resp_of(input logic [7:0] s, input int m, input logic [7:0] mk,
                                          input logic [7:0] d1, input logic [7:0] d2);
      case (m)
         1: return ~s & 8'hF7;
         2: return (s == 8'hA5) ? 8'h00 : ~s;
         3: return s;
         4: return ~s ^ mk;
         5: return d1;
         6: return d2;
         default: return ~s;
      endcase
   endfunction
   always @(posedge clk) begin
      a1 <= ~ia.stim;
      a2 <= a1;
      b1 <= ~ib.stim;
      b2 <= b1;
   end
   assign ia.start = start_a;
   assign ib.start = start_b;
   assign ia.resp  = resp_of(ia.stim, mode_a, fmask[ia.stim], a1, a2);
   assign ib.resp  = resp_of(ib.stim, mode_b, fmask[ib.stim], b1, b2);
   wire       m_busy = sel ? ib.busy : ia.busy;
   wire       m_done = sel ? ib.done : ia.done;
   wire       m_pass = sel ? ib.pass : ia.pass;
   wire       m_fev  = sel ? ib.first_err_valid : ia.first_err_valid;
   wire [7:0] m_fep  = sel ? ib.first_err_pattern : ia.first_err_pattern;
   wire [7:0] m_stim = sel ? ib.stim : ia.stim;
   wire [8:0] m_err  = sel ? ib.err_count : ia.err_count;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic set_start(input bit s, input logic v);
      if (s) start_b = v;
      else start_a = v;
   endtask
   task automatic run(input bit s, input bit extra, input int exp_cyc, input string tag);
      int  n;
      bit  busy_ok;
      sel     = s;
      busy_ok = 1'b1;
      @(posedge clk); #1;
      set_start(s, 1'b1);
      @(posedge clk); #1;
      set_start(s, 1'b0);
      chk({tag, "_acc_busy"}, m_busy, 1);
      chk({tag, "_acc_done"}, m_done, 0);
      chk({tag, "_acc_err"}, m_err, 0);
      chk({tag, "_acc_fev"}, m_fev, 0);
      chk({tag, "_acc_stim"}, m_stim, 0);
      for (n = 1; n <= 2000; n++) begin
         @(posedge clk); #1;
         if (extra) set_start(s, n == 100);
         if (m_done) break;
         if (!m_busy) busy_ok = 1'b0;
      end
      chk({tag, "_cycles"}, n, exp_cyc);
      chk({tag, "_busy_held"}, busy_ok, 1);
      chk({tag, "_busy_end"}, m_busy, 0);
      chk({tag, "_stim_end"}, m_stim, 8'hFF);
   endtask
   typedef struct {
      int         mode;
      int         err;
      logic       fev;
      logic [7:0] fep;
      logic       pass;
   } vec_t;
   vec_t tbl [5];
   initial begin
      tbl[0] = '{0, 0, 1'b0, 8'h00, 1'b1};
      tbl[1] = '{1, 128, 1'b1, 8'h00, 1'b0};
      tbl[2] = '{2, 1, 1'b1, 8'hA5, 1'b0};
      tbl[3] = '{3, 256, 1'b1, 8'h00, 1'b0};
      tbl[4] = '{0, 0, 1'b0, 8'h00, 1'b1};
      foreach (fmask[i]) fmask[i] = 8'h00;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; mode_a = 0; mode_b = 0;
      #12;
      chk("rst_stim", ia.stim, 0);
      chk("rst_busy", ia.busy, 0);
      chk("rst_done", ia.done, 0);
      chk("rst_pass", ia.pass, 0);
      chk("rst_err", ia.err_count, 0);
      chk("rst_fev", ia.first_err_valid, 0);
      chk("rst_fep", ia.first_err_pattern, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mode_a = tbl[i].mode;
         run(1'b0, 1'b0, 768, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_err", i), m_err, tbl[i].err);
         chk($sformatf("tbl%0d_fev", i), m_fev, tbl[i].fev);
         chk($sformatf("tbl%0d_fep", i), m_fep, tbl[i].fep);
         chk($sformatf("tbl%0d_pass", i), m_pass, tbl[i].pass);
         chk($sformatf("tbl%0d_done", i), m_done, 1);
      end
      mode_a = 0;
      run(1'b0, 1'b1, 768, "midstart");
      chk("midstart_pass", m_pass, 1);
      for (int r = 0; r < 3; r++) begin
         int         e_err;
         logic       e_fev;
         logic [7:0] e_fep;
         e_err = 0; e_fev = 1'b0; e_fep = 8'h00;
         foreach (fmask[i]) fmask[i] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         for (int p = 0; p < 256; p++)
            if (fmask[p] != 8'h00) begin
               if (!e_fev) e_fep = 8'(p);
               e_fev = 1'b1;
               e_err++;
            end
         mode_a = 4;
         run(1'b0, 1'b0, 768, $sformatf("rnd%0d", r));
         chk($sformatf("rnd%0d_err", r), m_err, e_err);
         chk($sformatf("rnd%0d_fev", r), m_fev, e_fev);
         chk($sformatf("rnd%0d_fep", r), m_fep, e_fep);
         chk($sformatf("rnd%0d_pass", r), m_pass, e_err == 0);
      end
      mode_b = 0;
      run(1'b1, 1'b0, 512, "s1_good");
      chk("s1_good_pass", m_pass, 1);
      mode_b = 5;
      run(1'b1, 1'b0, 512, "s1_late1");
      chk("s1_late1_pass", m_pass, 1);
      chk("s1_late1_err", m_err, 0);
      mode_b = 6;
      run(1'b1, 1'b0, 512, "s1_late2");
      chk("s1_late2_pass", m_pass, 0);
      chk("s1_late2_errmin", m_err >= 9'd255, 1);
      sel = 1'b0; mode_a = 0;
      @(posedge clk); #1;
      start_a = 1'b1;
      begin
         int n;
         for (n = 0; n < 2000 && !ia.done; n++) begin @(posedge clk); #1; end
         chk("hold_first_done", ia.done, 1);
         @(posedge clk); #1;
         chk("hold_done_pulse", ia.done, 0);
         chk("hold_rebusy", ia.busy, 1);
         chk("hold_restim", ia.stim, 0);
         start_a = 1'b0;
         for (n = 0; n < 2000 && !ia.done; n++) begin @(posedge clk); #1; end
         chk("hold_second_done", ia.done, 1);
      end
      mode_a = 3;
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int n = 0; n < 400 && ia.stim != 8'h40; n++) begin @(posedge clk); #1; end
      chk("rstmid_reached", ia.stim, 8'h40);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_stim", ia.stim, 0);
      chk("rstmid_busy", ia.busy, 0);
      chk("rstmid_err", ia.err_count, 0);
      chk("rstmid_fev", ia.first_err_valid, 0);
      chk("rstmid_fep", ia.first_err_pattern, 0);
      @(negedge clk) rst_n = 1'b1;
      mode_a = 0;
      run(1'b0, 1'b0, 768, "post_rst");
      chk("post_rst_pass", m_pass, 1);
      chk("post_rst_err", m_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
